// File: rtl/thermal_upscale_if.sv
// Pixel and sensor-write bus of the thermal upscaler.
// master: the VGA controller plus the sensor side; slave: thermal_upscale.
interface thermal_upscale_if #(
  parameter int pixel_bits_p = 4,
  parameter int addr_w_p     = 10
);
  logic                          ready_i;
  logic [2:0][pixel_bits_p-1:0]  data_o;
  logic                          wr_valid_i;
  logic                          wr_ready_o;
  logic [addr_w_p-1:0]           wr_addr_i;
  logic [7:0]                    wr_data_i;
  logic                          wr_frame_done_i;
  logic                          swap_o;

  modport master (
    output ready_i, wr_valid_i, wr_addr_i, wr_data_i, wr_frame_done_i,
    input  data_o, wr_ready_o, swap_o
  );

  modport slave (
    input  ready_i, wr_valid_i, wr_addr_i, wr_data_i, wr_frame_done_i,
    output data_o, wr_ready_o, swap_o
  );
endinterface

// File: rtl/thermal_upscale.sv
// Thermal frame upscaler: double-buffered src_w_p x src_h_p frame of 8-bit
// temperature codes, nearest-neighbour replicated by scale_p in both axes and
// mapped to RGB, one pixel per ready_i.
// Optional: define THERMAL_IRONBOW_EN for the ironbow palette instead of
// grayscale; latency is the same in both builds.
module thermal_upscale #(
  parameter int pixel_bits_p = 4,
  parameter int src_w_p      = 32,
  parameter int src_h_p      = 24,
  parameter int scale_p      = 20
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  thermal_upscale_if.slave  bus
);

  localparam int col_w_lp  = (src_w_p > 1) ? $clog2(src_w_p) : 1;
  localparam int row_w_lp  = (src_h_p > 1) ? $clog2(src_h_p) : 1;
  localparam int sub_w_lp  = (scale_p > 1) ? $clog2(scale_p) : 1;
  localparam int addr_w_lp = row_w_lp + col_w_lp;
  localparam int depth_lp  = 2 ** (addr_w_lp + 1);

  localparam logic [sub_w_lp-1:0] sub_max_lp = sub_w_lp'(scale_p - 1);
  localparam logic [col_w_lp-1:0] col_max_lp = col_w_lp'(src_w_p - 1);
  localparam logic [row_w_lp-1:0] row_max_lp = row_w_lp'(src_h_p - 1);

  typedef logic [2:0][pixel_bits_p-1:0] pixel_t;

  // Raster position and buffer state
  logic [sub_w_lp-1:0] r_sub_x, r_sub_y;
  logic [col_w_lp-1:0] r_col;
  logic [row_w_lp-1:0] r_row;
  logic                r_front;
  logic                r_swap_pending;
  logic                r_valid;
  logic                r_swap;

  logic [sub_w_lp-1:0] w_sub_x_nxt, w_sub_y_nxt;
  logic [col_w_lp-1:0] w_col_nxt;
  logic [row_w_lp-1:0] w_row_nxt;
  logic                w_frame_wrap;
  logic                w_swap;
  logic                w_front_nxt;

  // Write side
  logic [row_w_lp-1:0]  w_wr_row;
  logic [col_w_lp-1:0]  w_wr_col;
  logic                 w_wr_ready;
  logic                 w_wr_en;
  logic [addr_w_lp:0]   w_waddr;
  logic [addr_w_lp:0]   w_raddr;

  // Frame store
  logic [7:0] r_mem [depth_lp];
  logic [7:0] r_ram_q;

  // Temperature code to RGB
  function automatic pixel_t palette(input logic [7:0] t);
`ifdef THERMAL_IRONBOW_EN
    logic [pixel_bits_p-1:0] f;
    logic [pixel_bits_p-1:0] full;
    f       = t[5 -: pixel_bits_p];
    full    = '1;
    palette = '0;
    unique case (t[7:6])
      2'd0: begin palette[2] = '0;   palette[1] = '0;   palette[0] = f;    end
      2'd1: begin palette[2] = f;    palette[1] = '0;   palette[0] = full; end
      2'd2: begin palette[2] = full; palette[1] = f;    palette[0] = ~f;   end
      2'd3: begin palette[2] = full; palette[1] = full; palette[0] = f;    end
    endcase
`else
    palette[2] = t[7 -: pixel_bits_p];
    palette[1] = t[7 -: pixel_bits_p];
    palette[0] = t[7 -: pixel_bits_p];
`endif
  endfunction

  // Next raster position: sub_x -> col -> sub_y -> row cascade on ready_i
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_sub_x_nxt  = r_sub_x;
    w_col_nxt    = r_col;
    w_sub_y_nxt  = r_sub_y;
    w_row_nxt    = r_row;
    w_frame_wrap = 1'b0;
    if (bus.ready_i) begin
      if (r_sub_x != sub_max_lp) begin
        w_sub_x_nxt = r_sub_x + sub_w_lp'(1);
      end else begin
        w_sub_x_nxt = '0;
        if (r_col != col_max_lp) begin
          w_col_nxt = r_col + col_w_lp'(1);
        end else begin
          w_col_nxt = '0;
          if (r_sub_y != sub_max_lp) begin
            w_sub_y_nxt = r_sub_y + sub_w_lp'(1);
          end else begin
            w_sub_y_nxt = '0;
            if (r_row != row_max_lp) begin
              w_row_nxt = r_row + row_w_lp'(1);
            end else begin
              w_row_nxt    = '0;
              w_frame_wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  // A frame-done pulse arriving with the final ready_i swaps immediately
  assign w_swap      = w_frame_wrap & (r_swap_pending | bus.wr_frame_done_i);
  assign w_front_nxt = r_front ^ w_swap;

  // Writes are held off once the back buffer is declared complete
  assign w_wr_ready     = ~r_swap_pending & ~bus.wr_frame_done_i;
  assign bus.wr_ready_o = w_wr_ready;
  assign w_wr_row       = bus.wr_addr_i[addr_w_lp-1 -: row_w_lp];
  assign w_wr_col       = bus.wr_addr_i[col_w_lp-1:0];
  assign w_wr_en        = bus.wr_valid_i & w_wr_ready
                        & (int'(w_wr_row) < src_h_p) & (int'(w_wr_col) < src_w_p);
  assign w_waddr        = {~r_front, w_wr_row, w_wr_col};

  // Reading from the next-state position lets data_o follow ready_i by one cycle
  assign w_raddr = {w_front_nxt, w_row_nxt, w_col_nxt};

  // Raster counters, bank select and swap bookkeeping
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset_n_i) begin
      r_sub_x        <= '0;
      r_col          <= '0;
      r_sub_y        <= '0;
      r_row          <= '0;
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_valid        <= 1'b0;
      r_swap         <= 1'b0;
    end else begin
      r_sub_x <= w_sub_x_nxt;
      r_col   <= w_col_nxt;
      r_sub_y <= w_sub_y_nxt;
      r_row   <= w_row_nxt;
      r_front <= w_front_nxt;
      r_valid <= 1'b1;
      r_swap  <= w_swap;
      if (w_swap) begin
        r_swap_pending <= 1'b0;
      end else if (bus.wr_frame_done_i) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  // Dual-bank frame store: sensor writes the back bank, display reads the front
  always_ff @(posedge clk_i) begin
    // NOTE: the RAM has no reset so it maps onto block RAM; its contents
    // survive reset and data_o is masked until the first read completes.
    if (w_wr_en) begin
      r_mem[w_waddr] <= bus.wr_data_i;
    end
    r_ram_q <= r_mem[w_raddr];
  end

  // The RAM output register is the pixel register; only the colour map follows
  assign bus.data_o = r_valid ? palette(r_ram_q) : pixel_t'('0);
  assign bus.swap_o = r_swap;

endmodule
